// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam int unsigned PC_STEP     = 4;
  localparam logic [3:0]  WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per Wishbone classic
// read and hands {pc_o, instr_o} to IF/ID with a valid/stall handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no bus cycle; issue a fetch once the output buffer is free
// FETCH   | bus cycle open for pc; ack delivers the instruction
// DISCARD | bus cycle open but made stale by a redirect; drop its data
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  instr_valid_o
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [ADDR_WIDTH-1:0] pc_out_d;
  logic [DATA_WIDTH-1:0] instr_d;
  logic                  cyc_d;
  logic                  valid_d;
  logic                  buf_free;
  logic [ADDR_WIDTH-1:0] target;

  assign target   = {redirect_target_i[ADDR_WIDTH-1:2], 2'b00};
  assign buf_free = !instr_valid_o || !stall_i;

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = WB_SEL_WORD;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cyc_d    = wb_cyc_o;
    adr_d    = wb_adr_o;
    pc_out_d = pc_o;
    instr_d  = instr_o;
    // Holds while stalled, drops when consumed.
    valid_d  = instr_valid_o && stall_i;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (buf_free) begin
          cyc_d   = 1'b1;
          adr_d   = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect_i) begin
          pc_d    = target;
          valid_d = 1'b0;
          if (wb_ack_i) begin
            cyc_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (wb_ack_i) begin
          instr_d  = wb_dat_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + ADDR_WIDTH'(PC_STEP);
          cyc_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      DISCARD: begin
        // The bus cycle must complete; only the newest target survives.
        if (redirect_i) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= PC_ADDR;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_adr_o      <= PC_ADDR;
      pc_o          <= PC_ADDR;
      instr_o       <= DATA_WIDTH'(NOP_INSN);
      instr_valid_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wb_cyc_o      <= cyc_d;
      wb_stb_o      <= cyc_d;
      wb_adr_o      <= adr_d;
      pc_o          <= pc_out_d;
      instr_o       <= instr_d;
      instr_valid_o <= valid_d;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the architectural PC and fetches one 32-bit instruction per request over a Wishbone classic master port.
- Presents {pc_o, instr_o} with a valid/stall handshake to IF/ID.
- Handles redirects from branch resolution and discards any in-flight fetch made stale by a redirect.

Parameters:
- PC_ADDR, 32'h8000_0000, PC value loaded at reset.
- ADDR_WIDTH, 32, width of the PC and Wishbone address.
- DATA_WIDTH, 32, width of the instruction and Wishbone data.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous active-low reset; sampled on the rising edge of clk, 0 = reset.
- stall_i  in  1  IF/ID cannot accept this cycle.
- redirect_i  in  1  branch/jump taken or flush; load redirect_target_i.
- redirect_target_i  in  ADDR_WIDTH  new PC; bits [1:0] are ignored and treated as 00.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  always 0.
- wb_sel_o  out  4  always 4'hF.
- wb_adr_o  out  ADDR_WIDTH  fetch address.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- pc_o  out  ADDR_WIDTH  PC of instr_o.
- instr_o  out  DATA_WIDTH  fetched instruction.
- instr_valid_o  out  1  pc_o/instr_o hold a valid instruction.

Behaviour:
- All outputs are registered. Ports are clk and reset. reset is synchronous and active-low.
- Reset (reset==0 at an edge):
  - pc <= PC_ADDR; state <= IDLE.
  - cyc/stb <= 0; adr <= PC_ADDR.
  - instr_valid_o <= 0; instr_o <= 32'h0000_0013 (NOP); pc_o <= PC_ADDR.
  - Reset mid-fetch drops cyc/stb immediately, and any later ack is ignored.
- Handshake:
  - IF/ID consumes when instr_valid_o=1 and stall_i=0 at an edge.
  - While stall_i=1, pc_o, instr_o and instr_valid_o hold unchanged.
  - The output buffer is free when instr_valid_o=0 or it is being consumed this edge.
- States: IDLE, FETCH, DISCARD.
- IDLE:
  - redirect_i=1: pc <= {target[31:2],2'b00}; instr_valid_o <= 0; stay IDLE.
  - Else, if the buffer is free: cyc/stb <= 1, adr <= pc, go FETCH.
  - Else stay IDLE.
- FETCH: cyc/stb stay high and adr stays stable until ack; a Wishbone cycle is never aborted.
  - redirect_i=1 without ack: pc <= target; instr_valid_o <= 0; go DISCARD.
  - ack with redirect_i=0:
    - instr_o <= wb_dat_i; pc_o <= pc; instr_valid_o <= 1.
    - pc <= pc + 4, with modular wrap: 32'hFFFF_FFFC -> 0.
    - cyc/stb <= 0; go IDLE.
  - ack with redirect_i=1 in the same cycle: discard data; pc <= target; instr_valid_o <= 0; cyc/stb <= 0; go IDLE.
- DISCARD: cyc/stb stay high until ack.
  - On ack: drop data, cyc/stb <= 0, go IDLE.
  - A further redirect_i=1 overwrites pc with the newest target; the last target wins.
- Priority: reset > redirect_i > ack > stall_i. redirect_i clears instr_valid_o even when stall_i=1.
- Throughput:
  - One issue cycle plus the Wishbone wait.
  - With zero-wait ack (ack in the first FETCH cycle), one instruction every 2 cycles.
  - The minimum latency from redirect to a valid instruction is 3 edges.

Decomposition:
- Shared package holds:
  - the fetch_state_t enum {IDLE, FETCH, DISCARD};
  - the NOP_INSN constant 32'h0000_0013;
  - the PC_STEP constant 4;
  - WB_SEL_WORD = 4'hF.
- No sub-module: the PC register and FSM stay in one module.

Test Plan:
- Release reset, memory returns 0x00000093 with ack after 2 wait cycles -> wb_adr_o=0x8000_0000; instr_valid_o=1 with pc_o=0x8000_0000, instr_o=0x00000093; next wb_adr_o=0x8000_0004.
- Zero-wait memory, stall_i=0 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 issued every 2 cycles, with valid pulses in order.
- Hold stall_i=1 for 5 cycles after a valid -> outputs frozen, no new cyc asserted; release -> exactly one consume, then the next fetch issues.
- redirect_i=1, target=0x8000_0103 during FETCH, ack 3 cycles later with 0xDEADBEEF -> data never appears on instr_o; next wb_adr_o=0x8000_0100; first valid pc_o=0x8000_0100.
- redirect_i coincident with ack, and redirect_i while stalled with valid=1 -> instr_valid_o=0 next cycle; fetch resumes at the target.
- Assert reset=0 mid-FETCH, then ack arrives after reset is released -> cyc/stb low after the reset edge; stray ack is ignored; fetch restarts at 0x8000_0000.
